// File: rtl/detector_sequencer.sv
// Serializes parallel words MSB-first onto a sequence detector's data input
// and counts the detector hits that belong to each word.
module detector_sequencer #(
    parameter int WORD_W  = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_word,
    output logic              in_ready,
    output logic              det_data,
    input  logic              det_hit,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  hit_count,
    output logic              overflow
);

    localparam int              CW         = $clog2(WORD_W + 1);
    localparam logic [CW-1:0]   LAST_BIT   = CW'(WORD_W - 1);
    localparam logic [CW-1:0]   LAST_DRAIN = CW'((DET_LAT > 0) ? DET_LAT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [WORD_W-1:0] r_shift;
    logic [CW-1:0]     r_bit_cnt;
    logic              r_det_data;
    logic              r_bit_valid;
    logic [CNT_W-1:0]  r_hit_count;
    logic              r_overflow;
    logic              w_accept;
    logic              w_sample_en;
    logic [DET_LAT:0]  w_vchain;

    assign w_accept  = in_valid && (r_state == S_IDLE);
    assign det_data  = r_det_data;
    assign hit_count = r_hit_count;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                busy = 1'b1;
                if (r_bit_cnt == LAST_BIT) begin
                    w_state_next = (DET_LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_bit_cnt == LAST_DRAIN) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The MSB goes straight to det_data at accept; the shift register holds the rest.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_det_data  <= 1'b0;
            r_bit_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_shift     <= in_word << 1;
                        r_det_data  <= in_word[WORD_W-1];
                        r_bit_valid <= 1'b1;
                        r_bit_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    if (r_bit_cnt == LAST_BIT) begin
                        r_det_data  <= 1'b0;
                        r_bit_valid <= 1'b0;
                        r_bit_cnt   <= '0;
                    end else begin
                        r_det_data <= r_shift[WORD_W-1];
                        r_shift    <= r_shift << 1;
                        r_bit_cnt  <= r_bit_cnt + CW'(1);
                    end
                end
                S_DRAIN: begin
                    r_bit_cnt <= r_bit_cnt + CW'(1);
                end
                default: begin
                    r_det_data <= 1'b0;
                end
            endcase
        end
    end

    // Valid flag travels alongside each bit through the detector's latency.
    assign w_vchain[0] = r_bit_valid;

    generate
        for (genvar gi = 0; gi < DET_LAT; gi++) begin : g_vpipe
            logic r_vstage;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vstage <= 1'b0;
                end else begin
                    r_vstage <= w_vchain[gi];
                end
            end
            assign w_vchain[gi+1] = r_vstage;
        end
    endgenerate

    assign w_sample_en = w_vchain[DET_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else if (w_accept) begin
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else if (w_sample_en && det_hit) begin
            if (r_hit_count != CNT_MAX) begin
                r_hit_count <= r_hit_count + CNT_W'(1);
            end else begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_detector_sequencer.sv
// Bench for detector_sequencer: two instances (CNT_W=4 and CNT_W=1) each drive
// their own overlapping "101" detector model with one cycle of latency.
module tb_detector_sequencer;

    localparam int W  = 8;
    localparam int L  = 1;
    localparam int T  = W + L + 1;
    localparam int NC = T + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_word = 8'h00;

    logic       ready_a, data_a, busy_a, done_a, ov_a;
    logic [3:0] hc_a;
    logic       ready_b, data_b, busy_b, done_b, ov_b;
    logic [0:0] hc_b;

    logic [1:0] hist_a = 2'b00;
    logic [1:0] hist_b = 2'b00;
    logic       det_hit_a = 1'b0;
    logic       det_hit_b = 1'b0;

    int ncyc = 0;
    int tests_run = 0;
    int tests_failed = 0;

    logic [11:0] obs_data, obs_busy, obs_done, obs_done_b, obs_ready;
    logic [3:0]  obs_hc_a, obs_hc_a_hold;
    logic        obs_ov_a, obs_ov_a_hold, obs_hc_b, obs_ov_b;
    int          obs_stamp;
    bit          obs_timeout;

    detector_sequencer #(.WORD_W(W), .CNT_W(4), .DET_LAT(L)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .in_ready(ready_a), .det_data(data_a), .det_hit(det_hit_a),
        .busy(busy_a), .done(done_a), .hit_count(hc_a), .overflow(ov_a)
    );

    detector_sequencer #(.WORD_W(W), .CNT_W(1), .DET_LAT(L)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_word(in_word),
        .in_ready(ready_b), .det_data(data_b), .det_hit(det_hit_b),
        .busy(busy_b), .done(done_b), .hit_count(hc_b), .overflow(ov_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc <= ncyc + 1;

    always @(posedge clk) begin
        det_hit_a <= ({hist_a, data_a} == 3'b101);
        hist_a    <= {hist_a[0], data_a};
        det_hit_b <= ({hist_b, data_b} == 3'b101);
        hist_b    <= {hist_b[0], data_b};
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    // Words are always separated by at least three zero bits, so hits are
    // counted within the word with two leading zeros.
    function automatic int model_hits(input logic [7:0] w);
        logic [9:0] s;
        int h;
        s = {2'b00, w};
        h = 0;
        for (int i = 0; i < 8; i++) begin
            if (s[9-i -: 3] == 3'b101) h++;
        end
        return h;
    endfunction

    function automatic logic [11:0] range_mask(input int lo, input int hi);
        logic [11:0] m;
        m = '0;
        for (int c = lo; c <= hi; c++) m[c] = 1'b1;
        return m;
    endfunction

    function automatic logic [11:0] exp_data(input logic [7:0] w);
        logic [11:0] m;
        m = '0;
        for (int c = 1; c <= W; c++) m[c] = w[W-c];
        return m;
    endfunction

    // Drives one word and records per-cycle observations for cycles 1..NC after accept.
    task automatic xfer(input logic [7:0] w, input bit keep_valid,
                        input int pulse_c, input logic [7:0] pulse_w);
        int waits;
        waits       = 0;
        in_valid    = 1'b1;
        in_word     = w;
        obs_timeout = 1'b0;
        obs_data    = '0;
        obs_busy    = '0;
        obs_done    = '0;
        obs_done_b  = '0;
        obs_ready   = '0;
        obs_hc_a    = 'x;
        obs_ov_a    = 'x;
        obs_hc_b    = 'x;
        obs_ov_b    = 'x;
        while (ready_a !== 1'b1) begin
            if (waits >= 50) begin
                obs_timeout = 1'b1;
                in_valid    = 1'b0;
                $display("[TB] xfer word=%h never accepted", w);
                return;
            end
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        obs_stamp = ncyc;
        for (int c = 1; c <= NC; c++) begin
            if (c > 1) @(negedge clk);
            obs_data[c]   = data_a;
            obs_busy[c]   = busy_a;
            obs_done[c]   = done_a;
            obs_done_b[c] = done_b;
            obs_ready[c]  = ready_a;
            if (c == T) begin
                obs_hc_a = hc_a;
                obs_ov_a = ov_a;
                obs_hc_b = hc_b[0];
                obs_ov_b = ov_b;
            end
            if (c == NC) begin
                obs_hc_a_hold = hc_a;
                obs_ov_a_hold = ov_a;
            end
            if (c == 1 && !keep_valid) in_valid = 1'b0;
            if (c == pulse_c) begin
                in_valid = 1'b1;
                in_word  = pulse_w;
            end
            if (c == pulse_c + 1) begin
                in_valid = 1'b0;
                in_word  = w;
            end
        end
        $display("[TB] xfer word=%h hit_a=%0d ov_a=%0d hit_b=%0d ov_b=%0d", w, obs_hc_a, obs_ov_a,
                 obs_hc_b, obs_ov_b);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({ready_a, data_a, busy_a, done_a} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready/data/busy/done got %b required 1000",
                     {ready_a, data_a, busy_a, done_a});
        end
        tests_run++;
        if ({hc_a, ov_a, hc_b, ov_b} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_count: hc_a/ov_a/hc_b/ov_b got %b required 0", {hc_a, ov_a, hc_b, ov_b});
        end
    endtask

    task automatic test_basic_word();
        xfer(8'b10101010, 1'b0, -1, 8'h00);
        tests_run++;
        if (obs_timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_accept: timeout got %0d required 0", obs_timeout);
        end
        tests_run++;
        if (obs_data !== exp_data(8'b10101010)) begin
            tests_failed++;
            $display("FAIL basic_data: got %b required %b", obs_data, exp_data(8'b10101010));
        end
        tests_run++;
        if (obs_busy !== range_mask(1, W + L)) begin
            tests_failed++;
            $display("FAIL basic_busy: got %b required %b", obs_busy, range_mask(1, W + L));
        end
        tests_run++;
        if (obs_done !== range_mask(T, T)) begin
            tests_failed++;
            $display("FAIL basic_done: got %b required %b", obs_done, range_mask(T, T));
        end
        tests_run++;
        if (obs_ready !== range_mask(NC, NC)) begin
            tests_failed++;
            $display("FAIL basic_ready: got %b required %b", obs_ready, range_mask(NC, NC));
        end
        tests_run++;
        if ({obs_hc_a, obs_ov_a} !== {4'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_count: got hc=%0d ov=%0d required hc=3 ov=0", obs_hc_a, obs_ov_a);
        end
        tests_run++;
        if ({obs_hc_a_hold, obs_ov_a_hold} !== {4'd3, 1'b0}) begin
            tests_failed++;
            $display("FAIL basic_hold: got hc=%0d ov=%0d required hc=3 ov=0", obs_hc_a_hold, obs_ov_a_hold);
        end
    endtask

    task automatic test_back_to_back();
        int s1;
        xfer(8'h00, 1'b1, -1, 8'h00);
        s1 = obs_stamp;
        tests_run++;
        if (obs_done !== range_mask(T, T) || obs_hc_a !== 4'd0) begin
            tests_failed++;
            $display("FAIL b2b_first: done %b hc=%0d required done %b hc=0", obs_done, obs_hc_a,
                     range_mask(T, T));
        end
        xfer(8'hFF, 1'b0, -1, 8'h00);
        tests_run++;
        if (obs_stamp - s1 !== W + L + 2) begin
            tests_failed++;
            $display("FAIL b2b_period: got %0d cycles required %0d", obs_stamp - s1, W + L + 2);
        end
        tests_run++;
        if (obs_done !== range_mask(T, T) || obs_hc_a !== 4'd0 || obs_data !== exp_data(8'hFF)) begin
            tests_failed++;
            $display("FAIL b2b_second: done %b hc=%0d data %b required done %b hc=0 data %b",
                     obs_done, obs_hc_a, obs_data, range_mask(T, T), exp_data(8'hFF));
        end
    endtask

    task automatic test_saturate();
        xfer(8'b01010101, 1'b0, -1, 8'h00);
        tests_run++;
        if ({obs_hc_b, obs_ov_b} !== 2'b11) begin
            tests_failed++;
            $display("FAIL sat_cnt1: got hc=%0d ov=%0d required hc=1 ov=1", obs_hc_b, obs_ov_b);
        end
        tests_run++;
        if ({obs_hc_a, obs_ov_a} !== {4'd3, 1'b0} || obs_done_b !== range_mask(T, T)) begin
            tests_failed++;
            $display("FAIL sat_cnt4: got hc=%0d ov=%0d done_b %b required hc=3 ov=0 done_b %b",
                     obs_hc_a, obs_ov_a, obs_done_b, range_mask(T, T));
        end
        xfer(8'h00, 1'b0, -1, 8'h00);
        tests_run++;
        if ({obs_hc_b, obs_ov_b} !== 2'b00) begin
            tests_failed++;
            $display("FAIL sat_clear: got hc=%0d ov=%0d required hc=0 ov=0", obs_hc_b, obs_ov_b);
        end
    endtask

    task automatic test_ignore_busy();
        int ndone;
        xfer(8'h00, 1'b0, 3, 8'hAA);
        tests_run++;
        if (obs_ready !== range_mask(NC, NC)) begin
            tests_failed++;
            $display("FAIL ignore_ready: got %b required %b", obs_ready, range_mask(NC, NC));
        end
        tests_run++;
        if (obs_hc_a !== 4'd0 || obs_data !== exp_data(8'h00) || obs_done !== range_mask(T, T)) begin
            tests_failed++;
            $display("FAIL ignore_result: hc=%0d data %b done %b required hc=0 data 0 done %b",
                     obs_hc_a, obs_data, obs_done, range_mask(T, T));
        end
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_a === 1'b1) ndone++;
        end
        tests_run++;
        if (ndone !== 0 || ready_a !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignore_extra: done pulses %0d ready %b required 0 pulses ready 1", ndone, ready_a);
        end
    endtask

    task automatic test_mid_reset();
        int waits;
        int ndone;
        waits    = 0;
        in_valid = 1'b1;
        in_word  = 8'b10101010;
        while (ready_a !== 1'b1 && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({ready_a, data_a, busy_a, done_a} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL midrst_ctrl: ready/data/busy/done got %b required 1000",
                     {ready_a, data_a, busy_a, done_a});
        end
        tests_run++;
        if ({hc_a, ov_a, hc_b, ov_b} !== 7'b0) begin
            tests_failed++;
            $display("FAIL midrst_count: got %b required 0", {hc_a, ov_a, hc_b, ov_b});
        end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) ndone++;
        end
        tests_run++;
        if (ndone !== 0) begin
            tests_failed++;
            $display("FAIL midrst_quiet: busy/done cycles %0d required 0", ndone);
        end
        xfer(8'b10101010, 1'b0, -1, 8'h00);
        tests_run++;
        if ({obs_hc_a, obs_ov_a} !== {4'd3, 1'b0} || obs_done !== range_mask(T, T)) begin
            tests_failed++;
            $display("FAIL midrst_after: hc=%0d ov=%0d done %b required hc=3 ov=0 done %b",
                     obs_hc_a, obs_ov_a, obs_done, range_mask(T, T));
        end
    endtask

    task automatic test_random();
        logic [7:0] w;
        int h;
        for (int n = 0; n < 30; n++) begin
            w = 8'($urandom);
            if ($urandom_range(0, 3) == 0) w = w | 8'b10101010;
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(w, 1'b0, -1, 8'h00);
            h = model_hits(w);
            tests_run++;
            if (obs_timeout !== 1'b0 || obs_data !== exp_data(w) || obs_done !== range_mask(T, T)) begin
                tests_failed++;
                $display("FAIL rand_timing word=%h: data %b done %b required data %b done %b",
                         w, obs_data, obs_done, exp_data(w), range_mask(T, T));
            end
            tests_run++;
            if ({obs_hc_a, obs_ov_a} !== {4'((h > 15) ? 15 : h), 1'(h > 15)}) begin
                tests_failed++;
                $display("FAIL rand_cnt4 word=%h: got hc=%0d ov=%0d required hc=%0d ov=%0d",
                         w, obs_hc_a, obs_ov_a, (h > 15) ? 15 : h, h > 15);
            end
            tests_run++;
            if ({obs_hc_b, obs_ov_b} !== {1'(h >= 1), 1'(h > 1)}) begin
                tests_failed++;
                $display("FAIL rand_cnt1 word=%h: got hc=%0d ov=%0d required hc=%0d ov=%0d",
                         w, obs_hc_b, obs_ov_b, h >= 1, h > 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_word();
        test_back_to_back();
        test_saturate();
        test_ignore_busy();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
